// File: rtl/uart_boot_pkg.sv
// Shared states and handshake byte codes for the UART boot loader.
// No logic; types and constants only.
// Imported by the loader top and its bench.
package uart_boot_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_SIZE,
        S_PROG,
        S_CSUM,
        S_ACK,
        S_NAK,
        S_DATA
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h99;
    localparam logic [7:0] ACK_BYTE  = 8'hAA;
    localparam logic [7:0] NAK_BYTE  = 8'h55;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Bundle of UART rx/tx, instruction-memory and data-path signals of the loader.
// slave = loader side, master = host/UART/memory side.
// No flow control beyond tx_busy; pulses are single-cycle.
interface uart_boot_loader_if #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 14
);
    logic                    rx_ready;
    logic [7:0]              rdata;
    logic                    tx_busy;
    logic                    tx_start;
    logic [7:0]              sdata;
    logic                    instr_ready;
    logic [ADDR_W-1:0]       instr_addr;
    logic                    mem_ready;
    logic [WORD_BYTES*8-1:0] data;
    logic                    program_loaded;
    logic                    load_error;
    logic [31:0]             prog_size;

    modport slave (
        input  rx_ready, rdata, tx_busy,
        output tx_start, sdata, instr_ready, instr_addr, mem_ready, data,
               program_loaded, load_error, prog_size
    );

    modport master (
        output rx_ready, rdata, tx_busy,
        input  tx_start, sdata, instr_ready, instr_addr, mem_ready, data,
               program_loaded, load_error, prog_size
    );
endinterface

// File: rtl/uart_word_assembler.sv
// Packs bytes into WORD_BYTES-wide words (lane order set by BIG_ENDIAN), zero-padding on flush.
// Latency: word_o updates on the edge of the completing byte; done_o is combinational.
// Backpressure: none, accepts one byte per cycle.
module uart_word_assembler #(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    byte_vld_i,
    input  logic                    flush_i,
    input  logic [7:0]              byte_i,
    output logic                    done_o,
    output logic [WORD_BYTES*8-1:0] word_o
);
    localparam int W      = WORD_BYTES * 8;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    logic [LANE_W-1:0] lane_q, lane_d, pos;
    logic [W-1:0]      acc_q, acc_d, acc_nxt, word_q, word_d;

    // Write the byte into its lane; a completed word is published and the accumulator
    // restarts from zero so a flushed partial word carries zeros in unfilled lanes.
    always_comb begin
        pos     = BIG_ENDIAN ? (LAST_LANE - lane_q) : lane_q;
        acc_nxt = acc_q;
        acc_nxt[pos*8 +: 8] = byte_i;
        done_o  = byte_vld_i && ((lane_q == LAST_LANE) || flush_i);
        lane_d  = lane_q;
        acc_d   = acc_q;
        word_d  = word_q;
        if (clr_i) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (byte_vld_i) begin
            if (done_o) begin
                lane_d = '0;
                acc_d  = '0;
                word_d = acc_nxt;
            end else begin
                lane_d = lane_q + 1'b1;
                acc_d  = acc_nxt;
            end
        end
    end

    // Lane counter, partial accumulator and held output word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            acc_q  <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: sync/size/program/ack handshake, word assembly, then post-program data words.
// Latency: instr_ready/mem_ready one cycle after the completing rx_ready; tx_start one cycle after state entry.
// Backpressure: tx waits on tx_busy indefinitely; rx accepted every cycle. Optional: UART_BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int WORD_BYTES     = 4,
    parameter bit BIG_ENDIAN     = 1'b1,
    parameter int MAX_PROG_BYTES = 65536,
    parameter int ADDR_W         = 14
) (
    input  logic              clock,
    input  logic              reset,
    uart_boot_loader_if.slave bus
);
    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       size_q, size_d, size_full;
    logic [31:0]       remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        sdata_q, sdata_d;
    logic              instr_rdy_q, instr_rdy_d;
    logic              mem_rdy_q, mem_rdy_d;
    logic              load_err_q, load_err_d;
    logic [31:0]       prog_size_q, prog_size_d;
    logic              asm_clr, asm_vld, asm_flush, asm_done;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;

    // Running mod-256 sum of program bytes, restarted while waiting for a size.
    always_comb begin
        csum_d = csum_q;
        if (state_q == S_SIZE)
            csum_d = '0;
        else if (state_q == S_PROG && bus.rx_ready)
            csum_d = csum_q + bus.rdata;
    end
`endif

    // Handshake FSM: next state, tx requests, size capture and assembler control.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        size_d      = size_q;
        remain_d    = remain_q;
        addr_d      = instr_rdy_q ? addr_q + 1'b1 : addr_q;
        tx_start_d  = 1'b0;
        sdata_d     = sdata_q;
        load_err_d  = load_err_q;
        prog_size_d = prog_size_q;
        asm_clr     = 1'b0;
        asm_vld     = 1'b0;
        asm_flush   = 1'b0;
        size_full   = {bus.rdata, size_q[31:8]};
        case (state_q)
            S_SYNC: if (!bus.tx_busy) begin
                tx_start_d = 1'b1;
                sdata_d    = SYNC_BYTE;
                state_d    = S_SIZE;
            end
            S_SIZE: if (bus.rx_ready) begin
                size_d     = size_full;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    byte_cnt_d = '0;
                    if (size_full > 32'(MAX_PROG_BYTES)) begin
                        load_err_d = 1'b1;
                        state_d    = S_NAK;
                    end else if (size_full == '0) begin
                        state_d = S_ACK;
                    end else begin
                        prog_size_d = size_full;
                        remain_d    = size_full;
                        addr_d      = '0;
                        asm_clr     = 1'b1;
                        state_d     = S_PROG;
                    end
                end
            end
            S_PROG: if (bus.rx_ready) begin
                asm_vld   = 1'b1;
                asm_flush = (remain_q == 32'd1);
                remain_d  = remain_q - 32'd1;
                if (remain_q == 32'd1) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_ACK;
`endif
                end
            end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            S_CSUM: if (bus.rx_ready) begin
                if (bus.rdata == csum_q) begin
                    state_d = S_ACK;
                end else begin
                    load_err_d = 1'b1;
                    addr_d     = '0;
                    state_d    = S_NAK;
                end
            end
`endif
            S_ACK: if (!bus.tx_busy) begin
                tx_start_d = 1'b1;
                sdata_d    = ACK_BYTE;
                byte_cnt_d = '0;
                asm_clr    = 1'b1;
                state_d    = S_DATA;
            end
            S_NAK: if (!bus.tx_busy) begin
                tx_start_d = 1'b1;
                sdata_d    = NAK_BYTE;
                state_d    = S_SIZE;
            end
            S_DATA: asm_vld = bus.rx_ready;
            default: state_d = S_SYNC;
        endcase
        instr_rdy_d = asm_done && (state_q == S_PROG);
        mem_rdy_d   = asm_done && (state_q == S_DATA);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_SYNC;
            byte_cnt_q  <= '0;
            size_q      <= '0;
            remain_q    <= '0;
            addr_q      <= '0;
            tx_start_q  <= 1'b0;
            sdata_q     <= '0;
            instr_rdy_q <= 1'b0;
            mem_rdy_q   <= 1'b0;
            load_err_q  <= 1'b0;
            prog_size_q <= '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            size_q      <= size_d;
            remain_q    <= remain_d;
            addr_q      <= addr_d;
            tx_start_q  <= tx_start_d;
            sdata_q     <= sdata_d;
            instr_rdy_q <= instr_rdy_d;
            mem_rdy_q   <= mem_rdy_d;
            load_err_q  <= load_err_d;
            prog_size_q <= prog_size_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    uart_word_assembler #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_asm (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (asm_clr),
        .byte_vld_i (asm_vld),
        .flush_i    (asm_flush),
        .byte_i     (bus.rdata),
        .done_o     (asm_done),
        .word_o     (bus.data)
    );

    assign bus.tx_start       = tx_start_q;
    assign bus.sdata          = sdata_q;
    assign bus.instr_ready    = instr_rdy_q;
    assign bus.instr_addr     = addr_q;
    assign bus.mem_ready      = mem_rdy_q;
    assign bus.program_loaded = (state_q == S_DATA);
    assign bus.load_error     = load_err_q;
    assign bus.prog_size      = prog_size_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: big- and little-endian instances share one stimulus stream.
// Expected tx bytes and words are queued as stimulus is driven and popped by a negedge monitor.
// tx_busy is driven by the bench; no other backpressure.
module tb_uart_boot_loader;
    import uart_boot_pkg::*;

    localparam int WB   = 4;
    localparam int AW   = 14;
    localparam int MAXB = 65536;

    typedef struct packed {
        logic          mem;
        logic [AW-1:0] addr;
        logic [31:0]   dat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t       exp_q[2][$];
    logic [7:0] exp_tx[$];

    always #5 clock = ~clock;

    uart_boot_loader_if #(.WORD_BYTES(WB), .ADDR_W(AW)) ifb ();
    uart_boot_loader_if #(.WORD_BYTES(WB), .ADDR_W(AW)) ifl ();

    assign ifl.rx_ready = ifb.rx_ready;
    assign ifl.rdata    = ifb.rdata;
    assign ifl.tx_busy  = ifb.tx_busy;

    uart_boot_loader #(.WORD_BYTES(WB), .BIG_ENDIAN(1'b1), .MAX_PROG_BYTES(MAXB), .ADDR_W(AW)) dut_be (
        .clock (clock), .reset (reset), .bus (ifb)
    );
    uart_boot_loader #(.WORD_BYTES(WB), .BIG_ENDIAN(1'b0), .MAX_PROG_BYTES(MAXB), .ADDR_W(AW)) dut_le (
        .clock (clock), .reset (reset), .bus (ifl)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // b holds received bytes in order, first byte in b[7:0].
    function automatic logic [31:0] mk_word(input logic [31:0] b, input int n, input bit be);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (be) w[8*(WB-1-i) +: 8] = b[8*i +: 8];
            else    w[8*i +: 8]        = b[8*i +: 8];
        end
        return w;
    endfunction

    task automatic push_word(input logic mem, input int addr, input logic [31:0] b, input int n);
        exp_t e;
        e.mem  = mem;
        e.addr = AW'(addr);
        e.dat  = mk_word(b, n, 1'b1);
        exp_q[0].push_back(e);
        e.dat  = mk_word(b, n, 1'b0);
        exp_q[1].push_back(e);
    endtask

    task automatic mon_word(input int s, input logic ir, input logic mr,
                            input logic [AW-1:0] a, input logic [31:0] d);
        exp_t e;
        if (ir || mr) begin
            if (exp_q[s].size() == 0) begin
                chk($sformatf("spurious_word_dut%0d", s), {62'd0, ir, mr}, 64'd0);
            end else begin
                e = exp_q[s].pop_front();
                chk($sformatf("word_kind_dut%0d", s), {63'd0, mr}, {63'd0, e.mem});
                chk($sformatf("word_data_dut%0d", s), {32'd0, d}, {32'd0, e.dat});
                if (!e.mem) chk($sformatf("word_addr_dut%0d", s), {50'd0, a}, {50'd0, e.addr});
            end
        end
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clock) begin
        logic [7:0] t;
        if (!reset) begin
            if (ifb.tx_start) begin
                if (exp_tx.size() == 0) begin
                    chk("spurious_tx", {63'd0, ifb.tx_start}, 64'd0);
                end else begin
                    t = exp_tx.pop_front();
                    chk("tx_byte", {56'd0, ifb.sdata}, {56'd0, t});
                end
            end
            mon_word(0, ifb.instr_ready, ifb.mem_ready, ifb.instr_addr, ifb.data);
            mon_word(1, ifl.instr_ready, ifl.mem_ready, ifl.instr_addr, ifl.data);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifb.rx_ready = 1'b1;
        ifb.rdata    = b;
        @(posedge clock);
        #1;
        ifb.rx_ready = 1'b0;
    endtask

    task automatic send_size(input logic [31:0] sz);
        for (int i = 0; i < 4; i++) send_byte(sz[8*i +: 8]);
    endtask

    task automatic send_prog(input int n, input logic [7:0] first, input bit bad_csum);
        logic [31:0] acc;
        logic [7:0]  sum, bv;
        int          k, addr;
        acc = '0; sum = '0; k = 0; addr = 0;
        for (int i = 0; i < n; i++) begin
            bv = first + 8'(i);
            acc[8*k +: 8] = bv;
            k++;
            sum = sum + bv;
            if (k == WB || i == n - 1) begin
                push_word(1'b0, addr, acc, k);
                addr++;
                acc = '0;
                k = 0;
            end
            send_byte(bv);
        end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~sum : sum);
`else
        if (bad_csum) idle(1);
`endif
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        i = 0;
        while (i < budget && (exp_tx.size() != 0 || exp_q[0].size() != 0 || exp_q[1].size() != 0)) begin
            @(posedge clock);
            i++;
        end
        @(negedge clock);
        chk({tag, "_tx_left"}, 64'(exp_tx.size()), 64'd0);
        chk({tag, "_be_words_left"}, 64'(exp_q[0].size()), 64'd0);
        chk({tag, "_le_words_left"}, 64'(exp_q[1].size()), 64'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        ifb.rx_ready = 1'b0;
        ifb.rdata    = '0;
        ifb.tx_busy  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_tx_start", {63'd0, ifb.tx_start}, 64'd0);
        chk("rst_outs", {6'd0, ifb.sdata, ifb.instr_ready, ifb.instr_addr, ifb.mem_ready,
                         ifb.data, ifb.program_loaded, ifb.load_error}, 64'd0);
        chk("rst_prog_size", {32'd0, ifb.prog_size}, 64'd0);
        exp_tx.push_back(SYNC_BYTE);
        reset = 1'b0;
        drain("sync", 20);
        idle(5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // A: 8-byte program, then data words in S_DATA
        do_reset();
        exp_tx.push_back(ACK_BYTE);
        send_size(32'd8);
        send_prog(8, 8'h01, 1'b0);
        drain("A", 60);
        chk("A_loaded", {63'd0, ifb.program_loaded}, 64'd1);
        chk("A_prog_size", {32'd0, ifb.prog_size}, 64'd8);
        chk("A_addr_after", {50'd0, ifb.instr_addr}, 64'd2);
        chk("A_last_be", {32'd0, ifb.data}, 64'h05060708);
        chk("A_last_le", {32'd0, ifl.data}, 64'h08070605);
        push_word(1'b1, 0, 32'hDDCCBBAA, 4);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        drain("A_data", 20);
        chk("A_mem_le", {32'd0, ifl.data}, 64'hDDCCBBAA);
        send_byte(8'h01); send_byte(8'h02);
        idle(5);
        chk("A_hold_be", {32'd0, ifb.data}, 64'hAABBCCDD);

        // B: 6-byte program, partial last word zero padded
        do_reset();
        exp_tx.push_back(ACK_BYTE);
        send_size(32'd6);
        send_prog(6, 8'h11, 1'b0);
        drain("B", 60);
        chk("B_pad_be", {32'd0, ifb.data}, 64'h15160000);
        chk("B_pad_le", {32'd0, ifl.data}, 64'h00001615);
        chk("B_addr_after", {50'd0, ifb.instr_addr}, 64'd2);

        // C: oversize program rejected, then retried
        do_reset();
        exp_tx.push_back(NAK_BYTE);
        send_size(32'(MAXB + 1));
        drain("C_nak", 20);
        chk("C_err", {63'd0, ifb.load_error}, 64'd1);
        chk("C_not_loaded", {63'd0, ifb.program_loaded}, 64'd0);
        chk("C_size_kept", {32'd0, ifb.prog_size}, 64'd0);
        exp_tx.push_back(ACK_BYTE);
        send_size(32'd4);
        send_prog(4, 8'h21, 1'b0);
        drain("C_retry", 40);
        chk("C_err_sticky", {63'd0, ifb.load_error}, 64'd1);
        chk("C_prog_size", {32'd0, ifb.prog_size}, 64'd4);
        chk("C_loaded", {63'd0, ifb.program_loaded}, 64'd1);

        // D: ack held off by tx_busy
        do_reset();
        ifb.tx_busy = 1'b1;
        send_size(32'd4);
        send_prog(4, 8'h31, 1'b0);
        drain("D_words", 20);
        idle(20);
        chk("D_ack_waiting", {63'd0, ifb.program_loaded}, 64'd0);
        exp_tx.push_back(ACK_BYTE);
        ifb.tx_busy = 1'b0;
        drain("D_ack", 20);
        chk("D_loaded", {63'd0, ifb.program_loaded}, 64'd1);

        // E: empty program goes straight to ack
        do_reset();
        exp_tx.push_back(ACK_BYTE);
        send_size(32'd0);
        drain("E", 20);
        chk("E_loaded", {63'd0, ifb.program_loaded}, 64'd1);
        chk("E_size_not_latched", {32'd0, ifb.prog_size}, 64'd0);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        // F: bad checksum NAKs and rewinds the address, good one acks
        do_reset();
        exp_tx.push_back(NAK_BYTE);
        send_size(32'd4);
        send_prog(4, 8'h01, 1'b1);
        drain("F_nak", 30);
        chk("F_addr_rewound", {50'd0, ifb.instr_addr}, 64'd0);
        chk("F_err", {63'd0, ifb.load_error}, 64'd1);
        exp_tx.push_back(ACK_BYTE);
        send_size(32'd4);
        send_prog(4, 8'h01, 1'b0);
        drain("F_ack", 30);
        chk("F_loaded", {63'd0, ifb.program_loaded}, 64'd1);
`endif

        idle(10);
        chk("final_tx_left", 64'(exp_tx.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
